// File: rtl/counter_mod12_core_if.sv
// Bundles the load/count control inputs and the count output of the
// modulo-12 counter. The master side drives the controls and the slave
// side (the counter) drives the count.
interface counter_mod12_core_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic             mode;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;

    modport master (
        output load,
        output mode,
        output data_in,
        input  data_out
    );

    modport slave (
        input  load,
        input  mode,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/counter_mod12_core.sv
// Modulo-12 up/down counter with parallel load.
// Priority at each rising edge is reset, then load, then count.
// Loads of 12..15 are forced to 0. Wrap-around uses an explicit compare.
// The count is driven straight from a register.
module counter_mod12_core #(
    parameter int MODULUS = 12,
    parameter int WIDTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    counter_mod12_core_if.slave bus
);
    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    // Next count value for the load/count paths; reset is applied in the register
    always_comb begin
        w_next = r_count;
        if (bus.load) begin
            w_next = (bus.data_in <= LP_MAX) ? bus.data_in : '0;
        end else if (bus.mode) begin
            w_next = (r_count >= LP_MAX) ? '0 : r_count + 1'b1;
        end else begin
            w_next = (r_count == '0) ? LP_MAX : r_count - 1'b1;
        end
    end

    // Count register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign bus.data_out = r_count;
endmodule

// File: tb/tb_counter_mod12_core.sv
// Directed self-checking bench for counter_mod12_core, followed by a
// randomized run compared against a small behavioural reference.
module tb_counter_mod12_core;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [3:0] m;
    logic [3:0] exp_v;

    counter_mod12_core_if #(.WIDTH(4)) bus ();

    counter_mod12_core #(.MODULUS(12), .WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] expv);
        checks++;
        assert (bus.data_out === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, bus.data_out, expv);
        end
    endtask

    // Drive inputs, take one rising edge, settle away from the edge
    task automatic step(input logic r, input logic ld, input logic md, input logic [3:0] din);
        rst         = r;
        bus.load    = ld;
        bus.mode    = md;
        bus.data_in = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1; bus.load = 1'b0; bus.mode = 1'b1; bus.data_in = 4'd0;

        // Reset state
        step(1'b1, 1'b0, 1'b1, 4'd0);
        check("reset", 4'd0);

        // Count up 13 edges: 1..11,0,1
        for (int i = 1; i <= 13; i++) begin
            step(1'b0, 1'b0, 1'b1, 4'd0);
            check("up_seq", 4'((i) % 12));
        end

        // Reset then count down: 11,10,9
        step(1'b1, 1'b0, 1'b0, 4'd0);
        check("reset2", 4'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0); check("down_wrap", 4'd11);
        step(1'b0, 1'b0, 1'b0, 4'd0); check("down_10", 4'd10);
        step(1'b0, 1'b0, 1'b0, 4'd0); check("down_9", 4'd9);

        // Load 7 then count up through wrap
        step(1'b0, 1'b1, 1'b1, 4'd7); check("load7", 4'd7);
        step(1'b0, 1'b0, 1'b1, 4'd0); check("up_8", 4'd8);
        step(1'b0, 1'b0, 1'b1, 4'd0); check("up_9", 4'd9);
        step(1'b0, 1'b0, 1'b1, 4'd0); check("up_10", 4'd10);
        step(1'b0, 1'b0, 1'b1, 4'd0); check("up_11", 4'd11);
        step(1'b0, 1'b0, 1'b1, 4'd0); check("up_wrap", 4'd0);

        // Out-of-range load, load 0 then down wrap
        step(1'b0, 1'b1, 1'b1, 4'd14); check("load14", 4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd0);  check("load0", 4'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0);  check("load0_down", 4'd11);

        // Reach 6, then reset and load on the same edge
        step(1'b0, 1'b1, 1'b1, 4'd5); check("load5", 4'd5);
        step(1'b0, 1'b0, 1'b1, 4'd0); check("up_6", 4'd6);
        step(1'b1, 1'b1, 1'b1, 4'd9); check("rst_over_load", 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd0); check("resume_up", 4'd1);

        // Mode change takes effect on the next edge
        step(1'b0, 1'b1, 1'b1, 4'd5); check("load5b", 4'd5);
        step(1'b0, 1'b0, 1'b1, 4'd0); check("mode_up_6", 4'd6);
        step(1'b0, 1'b0, 1'b0, 4'd0); check("mode_down_5", 4'd5);

        // Load boundaries
        step(1'b0, 1'b1, 1'b0, 4'd11); check("load11", 4'd11);
        step(1'b0, 1'b1, 1'b0, 4'd12); check("load12", 4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd15); check("load15", 4'd0);

        // Reset asserted between edges must wait for the next rising edge
        step(1'b0, 1'b0, 1'b1, 4'd0); check("pre_sync", 4'd1);
        rst = 1'b1;
        #3;
        check("sync_hold", 4'd1);
        @(posedge clk);
        #1;
        check("sync_apply", 4'd0);

        // Randomized run against a reference model
        m = 4'd0;
        for (int i = 0; i < 1000; i++) begin
            logic r, ld, md;
            logic [3:0] din;
            r   = ($urandom_range(0, 15) == 0);
            ld  = ($urandom_range(0, 3) == 0);
            md  = 1'($urandom_range(0, 1));
            din = 4'($urandom_range(0, 15));
            if (r)            exp_v = 4'd0;
            else if (ld)      exp_v = (din < 4'd12) ? din : 4'd0;
            else if (md)      exp_v = (m == 4'd11) ? 4'd0 : m + 4'd1;
            else              exp_v = (m == 4'd0) ? 4'd11 : m - 4'd1;
            step(r, ld, md, din);
            check("random", exp_v);
            checks++;
            assert (bus.data_out <= 4'd11)
            else begin
                failures++;
                $error("FAIL range observed=%0d expected=<=11", bus.data_out);
            end
            m = exp_v;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
